rv32_execute_pipe: RTL and testbench

- Parametrised execute stage between decode and memory access, with registered outputs.
- Adds to the previous execute stage: a valid bit, a stall/flush handshake, branch/jump resolution with target calculation, and an optional iterative multiplier.
- The multiplier is a state machine that stalls upstream stages while it runs.

---
 rtl/rv32_execute_pkg.sv | 46 ++++
 rtl/rv32_execute_pipe_if.sv | 57 +++++
 rtl/rv32_mul_iter.sv | 92 +++++++++
 rtl/rv32_execute_pipe.sv | 154 +++++++++++++++
 tb/tb_rv32_execute_pipe.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_execute_pkg.sv
// Shared types and constants for the rv32 execute stage.
// The optional iterative multiplier is enabled with RV32_EXECUTE_MULDIV_EN.
package rv32_execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7
    } alu_op_e;

    // JAL and JALR share BR_JUMP; alu_src1 picks the target base (PC for JAL, RS1 for JALR).
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JUMP = 3'd7
    } branch_op_e;

    typedef enum logic [1:0] {
        MUL_MUL    = 2'd0,
        MUL_MULH   = 2'd1,
        MUL_MULHSU = 2'd2,
        MUL_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

endpackage

// File: rtl/rv32_execute_pipe_if.sv
// Decode-to-execute and execute-to-memory signal bundle for rv32_execute_pipe.
// The mul_state_dbg field only moves when RV32_EXECUTE_MULDIV_EN is defined.
interface rv32_execute_pipe_if #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
);
    import rv32_execute_pkg::*;

    // Handshake: valid_in marks a real instruction; upstream holds it while stall_out is high;
    // stall_in freezes the registered outputs; flush_in turns this stage's result into a bubble.
    logic                valid_in;
    logic                stall_in;
    logic                flush_in;
    logic                stall_out;
    alu_op_e             alu_op_in;
    logic                alu_sub_sra_in;
    logic                alu_src1_in;
    logic                alu_src2_in;
    branch_op_e          branch_op_in;
    logic                mul_en_in;
    mul_op_e             mul_op_in;
    logic                mem_read_en_in;
    logic                mem_write_en_in;
    logic                rd_writeback_in;
    logic [REG_BITS-1:0] rd_in;
    logic [XLEN-1:0]     pc_in;
    logic [XLEN-1:0]     rs1_value_in;
    logic [XLEN-1:0]     rs2_value_in;
    logic [XLEN-1:0]     imm_in;
    logic                valid_out;
    logic                mem_read_en_out;
    logic                mem_write_en_out;
    logic                rd_writeback_out;
    logic [REG_BITS-1:0] rd_out;
    logic [XLEN-1:0]     result_out;
    logic [XLEN-1:0]     rs2_value_out;
    logic [XLEN-1:0]     branch_pc_out;
    logic                branch_taken_out;
    mul_state_e          mul_state_dbg;

    modport master (
        output valid_in, stall_in, flush_in, alu_op_in, alu_sub_sra_in, alu_src1_in, alu_src2_in,
               branch_op_in, mul_en_in, mul_op_in, mem_read_en_in, mem_write_en_in,
               rd_writeback_in, rd_in, pc_in, rs1_value_in, rs2_value_in, imm_in,
        input  stall_out, valid_out, mem_read_en_out, mem_write_en_out, rd_writeback_out,
               rd_out, result_out, rs2_value_out, branch_pc_out, branch_taken_out, mul_state_dbg
    );

    modport slave (
        input  valid_in, stall_in, flush_in, alu_op_in, alu_sub_sra_in, alu_src1_in, alu_src2_in,
               branch_op_in, mul_en_in, mul_op_in, mem_read_en_in, mem_write_en_in,
               rd_writeback_in, rd_in, pc_in, rs1_value_in, rs2_value_in, imm_in,
        output stall_out, valid_out, mem_read_en_out, mem_write_en_out, rd_writeback_out,
               rd_out, result_out, rs2_value_out, branch_pc_out, branch_taken_out, mul_state_dbg
    );

endinterface

// File: rtl/rv32_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle on operand magnitudes,
// sign restored at the end. Instantiated only when RV32_EXECUTE_MULDIV_EN is defined.
module rv32_mul_iter
    import rv32_execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic              i_hold,
    input  mul_op_e           i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic              o_mul_hold,
    output logic              o_done,
    output logic [2*XLEN-1:0] o_product,
    output mul_state_e        o_state
);
    localparam int CW = $clog2(XLEN);

    mul_state_e        r_state;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mplier;
    logic              r_neg;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;

    // MULH treats both operands as signed, MULHSU only rs1; MUL's low half is sign-agnostic.
    assign w_a_neg = ((i_op == MUL_MULH) || (i_op == MUL_MULHSU)) && i_a[XLEN-1];
    assign w_b_neg = (i_op == MUL_MULH) && i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= MUL_IDLE;
            r_count  <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        r_state  <= MUL_BUSY;
                        r_count  <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                    end
                end
                MUL_BUSY: begin
                    if (i_flush) begin
                        r_state <= MUL_IDLE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                        if (r_count == CW'(XLEN - 1)) begin
                            r_state <= MUL_DONE;
                        end
                    end
                end
                MUL_DONE: begin
                    if (i_flush || !i_hold) begin
                        r_state <= MUL_IDLE;
                    end
                end
                default: r_state <= MUL_IDLE;
            endcase
        end
    end

    assign o_mul_hold = ((r_state == MUL_IDLE) && i_start) || (r_state == MUL_BUSY) ||
                        ((r_state == MUL_DONE) && i_hold);
    assign o_done     = (r_state == MUL_DONE);
    assign o_product  = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign o_state    = r_state;

endmodule

// File: rtl/rv32_execute_pipe.sv
// Execute stage: ALU, branch/jump resolution and registered outputs toward memory access.
// Define RV32_EXECUTE_MULDIV_EN to add the iterative multiplier that stalls upstream.
module rv32_execute_pipe
    import rv32_execute_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input logic                clk,
    input logic                reset,
    rv32_execute_pipe_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]     w_op1, w_op2, w_alu, w_sra, w_pc_imm, w_rs1_imm;
    logic [XLEN-1:0]     w_target, w_link, w_result, w_mul_result;
    logic [SHW-1:0]      w_shamt;
    logic                w_eq, w_lt, w_ltu, w_taken, w_is_jump;
    logic                w_mul_hold, w_mul_done, w_advance;

    logic                r_valid, r_mem_read, r_mem_write, r_rd_wb, r_taken;
    logic [REG_BITS-1:0] r_rd;
    logic [XLEN-1:0]     r_result, r_rs2, r_branch_pc;

    assign w_op1   = (bus.alu_src1_in == SRC1_PC) ? bus.pc_in : bus.rs1_value_in;
    assign w_op2   = (bus.alu_src2_in == SRC2_IMM) ? bus.imm_in : bus.rs2_value_in;
    assign w_shamt = w_op2[SHW-1:0];
    assign w_sra   = $signed(w_op1) >>> w_shamt;

    always_comb begin
        w_alu = '0;
        case (bus.alu_op_in)
            ALU_ADD:  w_alu = bus.alu_sub_sra_in ? (w_op1 - w_op2) : (w_op1 + w_op2);
            ALU_SLL:  w_alu = w_op1 << w_shamt;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
            ALU_XOR:  w_alu = w_op1 ^ w_op2;
            ALU_SRL:  w_alu = bus.alu_sub_sra_in ? w_sra : (w_op1 >> w_shamt);
            ALU_OR:   w_alu = w_op1 | w_op2;
            ALU_AND:  w_alu = w_op1 & w_op2;
            default:  w_alu = '0;
        endcase
    end

    assign w_eq  = (bus.rs1_value_in == bus.rs2_value_in);
    assign w_lt  = ($signed(bus.rs1_value_in) < $signed(bus.rs2_value_in));
    assign w_ltu = (bus.rs1_value_in < bus.rs2_value_in);

    always_comb begin
        w_taken   = 1'b0;
        w_is_jump = 1'b0;
        case (bus.branch_op_in)
            BR_BEQ:  w_taken = w_eq;
            BR_BNE:  w_taken = !w_eq;
            BR_BLT:  w_taken = w_lt;
            BR_BGE:  w_taken = !w_lt;
            BR_BLTU: w_taken = w_ltu;
            BR_BGEU: w_taken = !w_ltu;
            BR_JUMP: begin
                w_taken   = 1'b1;
                w_is_jump = 1'b1;
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign w_pc_imm  = bus.pc_in + bus.imm_in;
    assign w_rs1_imm = bus.rs1_value_in + bus.imm_in;
    assign w_link    = bus.pc_in + XLEN'(4);
    assign w_target  = (w_is_jump && (bus.alu_src1_in == SRC1_RS1)) ?
                       {w_rs1_imm[XLEN-1:1], 1'b0} : w_pc_imm;

`ifdef RV32_EXECUTE_MULDIV_EN
    logic              w_mul_start;
    logic [2*XLEN-1:0] w_product;

    assign w_mul_start = bus.valid_in && bus.mul_en_in && !bus.flush_in;

    rv32_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_mul_start),
        .i_flush    (bus.flush_in),
        .i_hold     (bus.stall_in),
        .i_op       (bus.mul_op_in),
        .i_a        (bus.rs1_value_in),
        .i_b        (bus.rs2_value_in),
        .o_mul_hold (w_mul_hold),
        .o_done     (w_mul_done),
        .o_product  (w_product),
        .o_state    (bus.mul_state_dbg)
    );

    assign w_mul_result = (bus.mul_op_in == MUL_MUL) ? w_product[XLEN-1:0] : w_product[2*XLEN-1:XLEN];
`else
    logic w_unused_mul;

    assign w_unused_mul      = ^{bus.mul_en_in, bus.mul_op_in};
    assign w_mul_hold        = 1'b0;
    assign w_mul_done        = 1'b0;
    assign w_mul_result      = '0;
    assign bus.mul_state_dbg = MUL_IDLE;
`endif

    assign w_result      = w_mul_done ? w_mul_result : (w_is_jump ? w_link : w_alu);
    assign w_advance     = !bus.stall_in && !w_mul_hold;
    assign bus.stall_out = bus.stall_in || w_mul_hold;

    // Flush beats hold: the bubble is forced even when the data fields stay frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_rd_wb     <= 1'b0;
            r_taken     <= 1'b0;
            r_rd        <= '0;
            r_result    <= '0;
            r_rs2       <= '0;
            r_branch_pc <= '0;
        end else begin
            if (bus.flush_in) begin
                r_valid     <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_rd_wb     <= 1'b0;
                r_taken     <= 1'b0;
            end else if (w_advance) begin
                r_valid     <= bus.valid_in;
                r_mem_read  <= bus.valid_in && bus.mem_read_en_in;
                r_mem_write <= bus.valid_in && bus.mem_write_en_in;
                r_rd_wb     <= bus.valid_in && bus.rd_writeback_in && (bus.rd_in != '0);
                r_taken     <= bus.valid_in && w_taken;
            end
            if (w_advance) begin
                r_rd        <= bus.rd_in;
                r_result    <= w_result;
                r_rs2       <= bus.rs2_value_in;
                r_branch_pc <= w_target;
            end
        end
    end

    assign bus.valid_out        = r_valid;
    assign bus.mem_read_en_out  = r_mem_read;
    assign bus.mem_write_en_out = r_mem_write;
    assign bus.rd_writeback_out = r_rd_wb;
    assign bus.branch_taken_out = r_taken;
    assign bus.rd_out           = r_rd;
    assign bus.result_out       = r_result;
    assign bus.rs2_value_out    = r_rs2;
    assign bus.branch_pc_out    = r_branch_pc;

endmodule

// File: tb/tb_rv32_execute_pipe.sv
// Self-checking bench for rv32_execute_pipe: directed cases, randomized stall/flush traffic,
// and multiplier cases when RV32_EXECUTE_MULDIV_EN is defined.
module tb_rv32_execute_pipe;
    import rv32_execute_pkg::*;

    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;

    typedef struct packed {
        logic        valid;
        logic        mrd;
        logic        mwr;
        logic        wb;
        logic        taken;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] rs2;
        logic [31:0] bpc;
    } out_t;

    localparam int EW = $bits(out_t);

    typedef struct {
        logic        valid;
        alu_op_e     alu_op;
        logic        sub_sra;
        logic        src1;
        logic        src2;
        branch_op_e  br;
        logic        mul_en;
        mul_op_e     mul_op;
        logic        mrd;
        logic        mwr;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } instr_t;

    logic          clk;
    logic          reset;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [EW-1:0] exp_q[$];

    rv32_execute_pipe_if #(.XLEN(XLEN), .REG_BITS(REG_BITS)) bus ();

    rv32_execute_pipe #(.XLEN(XLEN), .REG_BITS(REG_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic out_t observed();
        out_t o;
        o.valid  = bus.valid_out;
        o.mrd    = bus.mem_read_en_out;
        o.mwr    = bus.mem_write_en_out;
        o.wb     = bus.rd_writeback_out;
        o.taken  = bus.branch_taken_out;
        o.rd     = bus.rd_out;
        o.result = bus.result_out;
        o.rs2    = bus.rs2_value_out;
        o.bpc    = bus.branch_pc_out;
        return o;
    endfunction

    task automatic check_outputs(input logic [EW-1:0] e_vec, input string ctx);
        out_t e;
        out_t o;
        e = out_t'(e_vec);
        o = observed();
        chk({ctx, ".valid"},  o.valid,  e.valid);
        chk({ctx, ".mrd"},    o.mrd,    e.mrd);
        chk({ctx, ".mwr"},    o.mwr,    e.mwr);
        chk({ctx, ".wb"},     o.wb,     e.wb);
        chk({ctx, ".taken"},  o.taken,  e.taken);
        chk({ctx, ".rd"},     o.rd,     e.rd);
        chk({ctx, ".result"}, o.result, e.result);
        chk({ctx, ".rs2"},    o.rs2,    e.rs2);
        chk({ctx, ".bpc"},    o.bpc,    e.bpc);
    endtask

    // ---------------- reference model ----------------
    function automatic out_t ref_exec(input instr_t in);
        out_t        e;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned sh;
        logic        taken;
        a     = in.src1 ? in.pc : in.rs1;
        b     = in.src2 ? in.imm : in.rs2;
        sh    = b % 32;
        e     = '0;
        taken = 1'b0;
        case (in.alu_op)
            ALU_ADD:  e.result = in.sub_sra ? a - b : a + b;
            ALU_SLL:  e.result = a << sh;
            ALU_SLT:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  e.result = a ^ b;
            ALU_SRL:  e.result = (in.sub_sra && a[31]) ? ~((~a) >> sh) : (a >> sh);
            ALU_OR:   e.result = a | b;
            ALU_AND:  e.result = a & b;
            default:  e.result = 32'd0;
        endcase
        e.bpc = in.pc + in.imm;
        case (in.br)
            BR_BEQ:  taken = (in.rs1 == in.rs2);
            BR_BNE:  taken = (in.rs1 != in.rs2);
            BR_BLT:  taken = ($signed(in.rs1) < $signed(in.rs2));
            BR_BGE:  taken = ($signed(in.rs1) >= $signed(in.rs2));
            BR_BLTU: taken = (in.rs1 < in.rs2);
            BR_BGEU: taken = (in.rs1 >= in.rs2);
            BR_JUMP: begin
                taken    = 1'b1;
                e.result = in.pc + 32'd4;
                if (in.src1 == SRC1_RS1) e.bpc = (in.rs1 + in.imm) & 32'hFFFF_FFFE;
            end
            default: taken = 1'b0;
        endcase
        e.valid = in.valid;
        e.mrd   = in.valid & in.mrd;
        e.mwr   = in.valid & in.mwr;
        e.wb    = in.valid & in.wb & (in.rd != 5'd0);
        e.taken = in.valid & taken;
        e.rd    = in.rd;
        e.rs2   = in.rs2;
        return e;
    endfunction

    function automatic logic [31:0] ref_mul(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MUL_MULH:   p = 64'(sa * sb);
            MUL_MULHSU: p = 64'(sa * longint'({32'h0, b}));
            default:    p = {32'h0, a} * {32'h0, b};
        endcase
        return (op == MUL_MUL) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t idle_instr();
        instr_t in;
        in.valid = 1'b0; in.alu_op = ALU_ADD; in.sub_sra = 1'b0; in.src1 = SRC1_RS1;
        in.src2 = SRC2_RS2; in.br = BR_NONE; in.mul_en = 1'b0; in.mul_op = MUL_MUL;
        in.mrd = 1'b0; in.mwr = 1'b0; in.wb = 1'b0; in.rd = 5'd0;
        in.pc = 32'd0; in.rs1 = 32'd0; in.rs2 = 32'd0; in.imm = 32'd0;
        return in;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        in         = idle_instr();
        in.valid   = ($urandom_range(0, 4) != 0);
        in.alu_op  = alu_op_e'(4'($urandom_range(0, 7)));
        in.sub_sra = 1'($urandom_range(0, 1));
        in.src1    = 1'($urandom_range(0, 1));
        in.src2    = 1'($urandom_range(0, 1));
        in.br      = branch_op_e'(3'($urandom_range(0, 7)));
        in.mrd     = 1'($urandom_range(0, 1));
        in.mwr     = 1'($urandom_range(0, 1));
        in.wb      = 1'($urandom_range(0, 1));
        in.rd      = 5'($urandom_range(0, 31));
        in.pc      = $urandom & 32'hFFFF_FFFC;
        in.rs1     = $urandom;
        in.rs2     = ($urandom_range(0, 3) == 0) ? in.rs1 : $urandom;
        in.imm     = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            in.rs2 = 32'($urandom_range(0, 40));
            in.imm = 32'($urandom_range(0, 40));
        end
        return in;
    endfunction

    task automatic drive(input instr_t in);
        bus.valid_in        = in.valid;
        bus.alu_op_in       = in.alu_op;
        bus.alu_sub_sra_in  = in.sub_sra;
        bus.alu_src1_in     = in.src1;
        bus.alu_src2_in     = in.src2;
        bus.branch_op_in    = in.br;
        bus.mul_en_in       = in.mul_en;
        bus.mul_op_in       = in.mul_op;
        bus.mem_read_en_in  = in.mrd;
        bus.mem_write_en_in = in.mwr;
        bus.rd_writeback_in = in.wb;
        bus.rd_in           = in.rd;
        bus.pc_in           = in.pc;
        bus.rs1_value_in    = in.rs1;
        bus.rs2_value_in    = in.rs2;
        bus.imm_in          = in.imm;
    endtask

    task automatic run_one(input instr_t in, input string ctx);
        drive(in);
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        exp_q.push_back(ref_exec(in));
        step();
        check_outputs(exp_q.pop_front(), ctx);
    endtask

`ifdef RV32_EXECUTE_MULDIV_EN
    task automatic run_mul(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want, input string ctx);
        instr_t in;
        out_t   e;
        int     cyc;
        in        = idle_instr();
        in.valid  = 1'b1;
        in.mul_en = 1'b1;
        in.mul_op = op;
        in.rs1    = a;
        in.rs2    = b;
        in.wb     = 1'b1;
        in.rd     = 5'd9;
        in.pc     = 32'h0000_0300;
        drive(in);
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        #1;
        cyc = 0;
        while (bus.stall_out && cyc < 100) begin
            step();
            cyc++;
        end
        chk({ctx, ".stall_cycles"}, 64'(cyc), 64'(XLEN + 1));
        e        = ref_exec(in);
        e.result = ref_mul(op, a, b);
        exp_q.push_back(e);
        step();
        check_outputs(exp_q.pop_front(), ctx);
        chk({ctx, ".want"}, bus.result_out, want);
        drive(idle_instr());
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        instr_t in;
        out_t   cur;
        out_t   nxt;
        logic   stall;
        logic   flush;

        reset = 1'b1;
        drive(idle_instr());
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        step();
        step();
        check_outputs('0, "reset");
        chk("reset.stall_out", bus.stall_out, 1'b0);
        chk("reset.mul_state", bus.mul_state_dbg, MUL_IDLE);
        reset = 1'b0;

        // ADD wraps around
        in = idle_instr();
        in.valid = 1'b1; in.rs1 = 32'd5; in.rs2 = 32'hFFFF_FFFF; in.wb = 1'b1; in.rd = 5'd3;
        run_one(in, "add");
        chk("add.plan_result", bus.result_out, 32'd4);
        chk("add.plan_valid", bus.valid_out, 1'b1);

        // BLT signed vs BLTU unsigned on the same operands
        in = idle_instr();
        in.valid = 1'b1; in.br = BR_BLT; in.rs1 = 32'hFFFF_FFFE; in.rs2 = 32'd1;
        in.pc = 32'h100; in.imm = 32'h20;
        run_one(in, "blt");
        chk("blt.plan_taken", bus.branch_taken_out, 1'b1);
        chk("blt.plan_bpc", bus.branch_pc_out, 32'h120);
        in.br = BR_BLTU;
        run_one(in, "bltu");
        chk("bltu.plan_taken", bus.branch_taken_out, 1'b0);

        // JALR clears bit 0; JAL targets pc+imm
        in = idle_instr();
        in.valid = 1'b1; in.br = BR_JUMP; in.src1 = SRC1_RS1; in.rs1 = 32'h1001;
        in.imm = 32'd2; in.pc = 32'h40; in.wb = 1'b1; in.rd = 5'd1;
        run_one(in, "jalr");
        chk("jalr.plan_bpc", bus.branch_pc_out, 32'h1002);
        chk("jalr.plan_result", bus.result_out, 32'h44);
        chk("jalr.plan_taken", bus.branch_taken_out, 1'b1);
        in.src1 = SRC1_PC; in.pc = 32'h200; in.imm = 32'h10;
        run_one(in, "jal");
        chk("jal.plan_bpc", bus.branch_pc_out, 32'h210);

        // Stall holds outputs; flush during stall forces a bubble
        in = idle_instr();
        in.valid = 1'b1; in.rs1 = 32'd3; in.rs2 = 32'd4; in.wb = 1'b1; in.rd = 5'd7;
        run_one(in, "stall.issue");
        drive(rand_instr());
        bus.stall_in = 1'b1;
        #1;
        chk("stall.stall_out", bus.stall_out, 1'b1);
        step();
        chk("stall.hold_valid", bus.valid_out, 1'b1);
        chk("stall.hold_result", bus.result_out, 32'd7);
        bus.flush_in = 1'b1;
        step();
        chk("stall.flush_valid", bus.valid_out, 1'b0);
        chk("stall.flush_wb", bus.rd_writeback_out, 1'b0);
        chk("stall.flush_result", bus.result_out, 32'd7);
        bus.flush_in = 1'b0;
        step();
        chk("stall.after_valid", bus.valid_out, 1'b0);
        chk("stall.after_wb", bus.rd_writeback_out, 1'b0);
        bus.stall_in = 1'b0;
        in = idle_instr();
        run_one(in, "stall.release");

        // Randomized traffic with stall and flush
        cur = observed();
        repeat (300) begin
            in    = rand_instr();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive(in);
            bus.stall_in = stall;
            bus.flush_in = flush;
            #1;
            chk("rand.stall_out", bus.stall_out, stall);
            nxt = ref_exec(in);
            if (!stall) cur = nxt;
            if (flush) begin
                cur.valid = 1'b0;
                cur.mrd   = 1'b0;
                cur.mwr   = 1'b0;
                cur.wb    = 1'b0;
                cur.taken = 1'b0;
            end
            exp_q.push_back(cur);
            step();
            check_outputs(exp_q.pop_front(), "rand");
        end
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        drive(idle_instr());
        step();

`ifdef RV32_EXECUTE_MULDIV_EN
        run_mul(MUL_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulh");
        run_mul(MUL_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu");
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            run_mul(mul_op_e'(2'(k)), ra, rb, ref_mul(mul_op_e'(2'(k)), ra, rb), "mulrand");
        end

        // Flush in BUSY discards the product and releases the stall
        in = idle_instr();
        in.valid = 1'b1; in.mul_en = 1'b1; in.rs1 = 32'd9; in.rs2 = 32'd9;
        drive(in);
        repeat (5) step();
        bus.flush_in = 1'b1;
        step();
        chk("mulflush.valid", bus.valid_out, 1'b0);
        bus.flush_in = 1'b0;
        drive(idle_instr());
        #1;
        chk("mulflush.stall_out", bus.stall_out, 1'b0);
        chk("mulflush.state", bus.mul_state_dbg, MUL_IDLE);
        step();

        // Reset mid-BUSY, then a fresh MUL
        in = idle_instr();
        in.valid = 1'b1; in.mul_en = 1'b1; in.rs1 = 32'd3; in.rs2 = 32'd5;
        drive(in);
        repeat (10) step();
        drive(idle_instr());
        reset = 1'b1;
        step();
        check_outputs('0, "mulreset");
        chk("mulreset.stall_out", bus.stall_out, 1'b0);
        reset = 1'b0;
        run_mul(MUL_MUL, 32'd7, 32'd6, 32'd42, "mul7x6");
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
